// File: rtl/dtc_result_monitor.sv
// Streaming scorer behind the decision-tree classifier: accumulates exact-match,
// Hamming bit-error and worst per-sample error over a window, then reports once.
module dtc_result_monitor #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 256,
  localparam int CW = $clog2(WINDOW + 1),
  localparam int PW = $clog2(WIDTH + 1),
  localparam int BW = CW + PW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pred,
  input  logic [WIDTH-1:0] label,
  input  logic             flush,
  input  logic             clear,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [CW-1:0]    rep_samples,
  output logic [CW-1:0]    rep_match,
  output logic [BW-1:0]    rep_biterr,
  output logic [PW-1:0]    rep_worst
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] n;
    n = {PW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  logic [0:0]       state_r;
  logic             live_r;
  logic             v1_r;
  logic [WIDTH-1:0] d1_r;
  logic [CW-1:0]    issued_r, samples_r, match_r;
  logic [BW-1:0]    biterr_r;
  logic [PW-1:0]    worst_r;
  logic             flush_pend_r;
  logic             rep_valid_r;
  logic [CW-1:0]    rep_samples_r, rep_match_r;
  logic [BW-1:0]    rep_biterr_r;
  logic [PW-1:0]    rep_worst_r;

  logic             in_ready_s, accept_s, win_end_s, flush_go_s, flush_set_s;
  logic [PW-1:0]    pc_s, worst_nx_s;
  logic [CW-1:0]    samples_nx_s, match_nx_s;
  logic [BW-1:0]    biterr_nx_s;

  // Acceptance, next counter values from stage S2, and report triggers
  always_comb begin
    in_ready_s  = live_r && (state_r == ACCUM) && (issued_r != CW'(WINDOW))
                  && !flush_pend_r && !clear;
    accept_s    = in_valid && in_ready_s;
    pc_s        = popcount(d1_r);
    if (v1_r) begin
      samples_nx_s = samples_r + CW'(1);
      match_nx_s   = (d1_r == {WIDTH{1'b0}}) ? (match_r + CW'(1)) : match_r;
      biterr_nx_s  = biterr_r + BW'(pc_s);
      worst_nx_s   = (pc_s > worst_r) ? pc_s : worst_r;
    end else begin
      samples_nx_s = samples_r;
      match_nx_s   = match_r;
      biterr_nx_s  = biterr_r;
      worst_nx_s   = worst_r;
    end
    win_end_s   = v1_r && (samples_nx_s == CW'(WINDOW));
    flush_go_s  = flush_pend_r && !v1_r && (samples_r != {CW{1'b0}});
    // A flush on a completely empty monitor is dropped rather than producing an empty record
    flush_set_s = flush && (accept_s || v1_r || (samples_r != {CW{1'b0}})
                  || (issued_r != {CW{1'b0}}));
  end

  // Stage S1: register the error vector of each accepted pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_r <= 1'b0;
      v1_r   <= 1'b0;
      d1_r   <= {WIDTH{1'b0}};
    end else if (clear) begin
      live_r <= 1'b1;
      v1_r   <= 1'b0;
      d1_r   <= {WIDTH{1'b0}};
    end else begin
      live_r <= 1'b1;
      v1_r   <= accept_s;
      if (accept_s) d1_r <= pred ^ label;
    end
  end

  // Stage S2 accumulation plus ACCUM/REPORT control and the report register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ACCUM;
      issued_r      <= {CW{1'b0}};
      samples_r     <= {CW{1'b0}};
      match_r       <= {CW{1'b0}};
      biterr_r      <= {BW{1'b0}};
      worst_r       <= {PW{1'b0}};
      flush_pend_r  <= 1'b0;
      rep_valid_r   <= 1'b0;
      rep_samples_r <= {CW{1'b0}};
      rep_match_r   <= {CW{1'b0}};
      rep_biterr_r  <= {BW{1'b0}};
      rep_worst_r   <= {PW{1'b0}};
    end else if (clear) begin
      state_r       <= ACCUM;
      issued_r      <= {CW{1'b0}};
      samples_r     <= {CW{1'b0}};
      match_r       <= {CW{1'b0}};
      biterr_r      <= {BW{1'b0}};
      worst_r       <= {PW{1'b0}};
      flush_pend_r  <= 1'b0;
      rep_valid_r   <= 1'b0;
      rep_samples_r <= {CW{1'b0}};
      rep_match_r   <= {CW{1'b0}};
      rep_biterr_r  <= {BW{1'b0}};
      rep_worst_r   <= {PW{1'b0}};
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) issued_r <= issued_r + CW'(1);
          if (flush_set_s) flush_pend_r <= 1'b1;
          samples_r <= samples_nx_s;
          match_r   <= match_nx_s;
          biterr_r  <= biterr_nx_s;
          worst_r   <= worst_nx_s;
          if (win_end_s || flush_go_s) begin
            state_r       <= REPORT;
            rep_valid_r   <= 1'b1;
            rep_samples_r <= samples_nx_s;
            rep_match_r   <= match_nx_s;
            rep_biterr_r  <= biterr_nx_s;
            rep_worst_r   <= worst_nx_s;
          end
        end
        REPORT: begin
          if (rep_ready) begin
            state_r      <= ACCUM;
            rep_valid_r  <= 1'b0;
            issued_r     <= {CW{1'b0}};
            samples_r    <= {CW{1'b0}};
            match_r      <= {CW{1'b0}};
            biterr_r     <= {BW{1'b0}};
            worst_r      <= {PW{1'b0}};
            flush_pend_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ACCUM;
          rep_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_s;
  assign rep_valid   = rep_valid_r;
  assign rep_samples = rep_samples_r;
  assign rep_match   = rep_match_r;
  assign rep_biterr  = rep_biterr_r;
  assign rep_worst   = rep_worst_r;

endmodule

// File: tb/tb_dtc_result_monitor.sv
// Bench: directed table vectors on a WINDOW=4 instance, randomized traffic on a
// WINDOW=256 instance scored against a window-level reference model.
module tb_dtc_result_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_flush, a_clear, a_rep_valid, a_rep_ready;
  logic [7:0] a_pred, a_label;
  logic [2:0] a_samples, a_match;
  logic [6:0] a_biterr;
  logic [3:0] a_worst;

  logic       b_in_valid, b_in_ready, b_flush, b_clear, b_rep_valid, b_rep_ready;
  logic [7:0] b_pred, b_label;
  logic [8:0] b_samples, b_match;
  logic [12:0] b_biterr;
  logic [3:0] b_worst;

  dtc_result_monitor #(.WIDTH(8), .WINDOW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .pred(a_pred), .label(a_label), .flush(a_flush), .clear(a_clear),
    .rep_valid(a_rep_valid), .rep_ready(a_rep_ready), .rep_samples(a_samples),
    .rep_match(a_match), .rep_biterr(a_biterr), .rep_worst(a_worst));

  dtc_result_monitor #(.WIDTH(8), .WINDOW(256)) dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pred(b_pred), .label(b_label), .flush(b_flush), .clear(b_clear),
    .rep_valid(b_rep_valid), .rep_ready(b_rep_ready), .rep_samples(b_samples),
    .rep_match(b_match), .rep_biterr(b_biterr), .rep_worst(b_worst));

  typedef struct {
    logic [3:0][7:0] pred;
    logic [3:0][7:0] label;
    int n;
    bit fl;
    int samples, match, biterr, worst;
  } vec_t;

  typedef struct { int s, m, b, w; } rec_t;

  vec_t tbl[4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one table vector into dut4 and check the resulting record and its latency
  task automatic run_vec(input int idx, input bit hold);
    int lat;
    for (int i = 0; i < tbl[idx].n; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_pred     = tbl[idx].pred[i];
      a_label    = tbl[idx].label[i];
      chk($sformatf("v%0d_in_ready_%0d", idx, i), int'(a_in_ready), 1);
    end
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      a_flush    = (k == 1) && tbl[idx].fl;
      if (a_rep_valid) begin
        lat = k;
        break;
      end
    end
    a_flush = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, tbl[idx].fl ? 3 : 2);
    chk($sformatf("v%0d_samples", idx), int'(a_samples), tbl[idx].samples);
    chk($sformatf("v%0d_match", idx), int'(a_match), tbl[idx].match);
    chk($sformatf("v%0d_biterr", idx), int'(a_biterr), tbl[idx].biterr);
    chk($sformatf("v%0d_worst", idx), int'(a_worst), tbl[idx].worst);
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("v%0d_rep_valid_drop", idx), int'(a_rep_valid), 0);
      chk($sformatf("v%0d_in_ready_back", idx), int'(a_in_ready), 1);
    end
  endtask

  initial begin
    rec_t q[$];
    rec_t exp_r;
    int   acc_n, acc_m, acc_b, acc_w, pc, recs, bad;
    bit   closed;
    logic [2:0] s_samp, s_match;
    logic [6:0] s_bit;
    logic [3:0] s_worst;

    tbl[0] = '{pred: {8'h3C, 8'h0F, 8'hFF, 8'h00}, label: {8'h3C, 8'h0E, 8'h00, 8'h00},
               n: 4, fl: 1'b0, samples: 4, match: 2, biterr: 9, worst: 8};
    tbl[1] = '{pred: {8'h00, 8'h00, 8'h01, 8'hA5}, label: {8'h00, 8'h00, 8'h01, 8'h5A},
               n: 2, fl: 1'b1, samples: 2, match: 1, biterr: 8, worst: 8};
    tbl[2] = '{pred: {8'h55, 8'h55, 8'h55, 8'h55}, label: {8'h55, 8'h55, 8'h55, 8'h55},
               n: 4, fl: 1'b0, samples: 4, match: 4, biterr: 0, worst: 0};
    tbl[3] = '{pred: {8'h00, 8'hE0, 8'hC0, 8'h80}, label: {8'h00, 8'h00, 8'h00, 8'h00},
               n: 3, fl: 1'b1, samples: 3, match: 0, biterr: 6, worst: 3};

    rst_n = 1'b0;
    {a_in_valid, a_flush, a_clear, a_rep_ready, a_pred, a_label} = '0;
    {b_in_valid, b_flush, b_clear, b_rep_ready, b_pred, b_label} = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_rep_valid", int'(a_rep_valid), 0);
    chk("rst_fields", int'({a_samples, a_match, a_biterr, a_worst}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(a_in_ready), 1);

    // Full windows and flushed partial windows
    a_rep_ready = 1'b1;
    for (int v = 0; v < 4; v++) run_vec(v, 1'b0);

    // Flush on an idle, empty monitor produces nothing and leaves no pending flush
    @(negedge clk); a_flush = 1'b1;
    @(negedge clk); a_flush = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rep_valid || !a_in_ready) bad++;
    end
    chk("idle_flush_no_record", bad, 0);
    run_vec(0, 1'b0);

    // Back-pressure: record held stable, no input accepted
    a_rep_ready = 1'b0;
    run_vec(0, 1'b1);
    s_samp = a_samples; s_match = a_match; s_bit = a_biterr; s_worst = a_worst;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_pred     = 8'($urandom);
      a_label    = 8'($urandom);
      if (!a_rep_valid || a_in_ready || a_samples != s_samp || a_match != s_match ||
          a_biterr != s_bit || a_worst != s_worst) bad++;
    end
    chk("backpressure_hold", bad, 0);
    a_in_valid  = 1'b0;
    a_rep_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_rep_valid", int'(a_rep_valid), 0);
    chk("bp_release_in_ready", int'(a_in_ready), 1);
    run_vec(2, 1'b0);

    // Clear while a record is pending; the pair offered with clear is not taken
    a_rep_ready = 1'b0;
    run_vec(0, 1'b1);
    @(negedge clk);
    a_clear = 1'b1; a_in_valid = 1'b1; a_pred = 8'hFF; a_label = 8'h00;
    #1 chk("clear_in_ready", int'(a_in_ready), 0);
    @(negedge clk);
    a_clear = 1'b0; a_in_valid = 1'b0;
    chk("clear_rep_valid", int'(a_rep_valid), 0);
    a_rep_ready = 1'b1;
    run_vec(2, 1'b0);

    // Async reset two samples into a window
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_pred = 8'hFF; a_label = 8'h00;
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(a_in_ready), 0);
    chk("arst_rep_valid", int'(a_rep_valid), 0);
    chk("arst_fields", int'({a_samples, a_match, a_biterr, a_worst}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(0, 1'b0);

    // Randomized traffic on the WINDOW=256 instance against a window-level model
    acc_n = 0; acc_m = 0; acc_b = 0; acc_w = 0; recs = 0; closed = 1'b0;
    for (int cyc = 0; cyc < 2100; cyc++) begin
      @(negedge clk);
      if (cyc < 2000) begin
        b_in_valid  = ($urandom_range(0, 9) < 7);
        b_pred      = 8'($urandom);
        b_label     = ($urandom_range(0, 3) == 0) ? b_pred : 8'($urandom);
        b_rep_ready = ($urandom_range(0, 9) < 6);
        b_flush     = ($urandom_range(0, 299) == 0);
      end else begin
        b_in_valid  = 1'b0;
        b_rep_ready = 1'b1;
        b_flush     = (cyc == 2000);
      end
      chk("rand_in_ready", int'(b_in_ready), int'(!closed));
      if (b_in_valid && b_in_ready) begin
        pc = $countones(b_pred ^ b_label);
        acc_n++;
        acc_m += (pc == 0) ? 1 : 0;
        acc_b += pc;
        if (pc > acc_w) acc_w = pc;
        if (acc_n == 256) begin
          q.push_back('{s: acc_n, m: acc_m, b: acc_b, w: acc_w});
          acc_n = 0; acc_m = 0; acc_b = 0; acc_w = 0; closed = 1'b1;
        end
      end
      if (b_flush && !closed && acc_n > 0) begin
        q.push_back('{s: acc_n, m: acc_m, b: acc_b, w: acc_w});
        acc_n = 0; acc_m = 0; acc_b = 0; acc_w = 0; closed = 1'b1;
      end
      if (b_rep_valid && b_rep_ready) begin
        chk("rand_record_expected", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_r = q.pop_front();
          recs++;
          chk("rand_samples", int'(b_samples), exp_r.s);
          chk("rand_match", int'(b_match), exp_r.m);
          chk("rand_biterr", int'(b_biterr), exp_r.b);
          chk("rand_worst", int'(b_worst), exp_r.w);
        end
        closed = 1'b0;
      end
    end
    chk("rand_queue_drained", q.size(), 0);
    chk("rand_some_records", int'(recs >= 3), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtc_result_monitor.md
# dtc_result_monitor

Streaming scorer placed directly downstream of the decision-tree classifier stage. Each cycle it may accept one 8-bit class prediction from the classifier plus the golden label for the same sample. It accumulates exact-match count, total Hamming bit-error count and worst-case per-sample bit error over a fixed window. At window end, or on flush, it emits one summary record through a valid/ready handshake, holding off new input until the record is consumed.

## Interface
- WIDTH, 8, bit width of prediction and label
- WINDOW, 256, samples per report; integer power of two or not, must be ≥ 1
- CW (localparam), $clog2(WINDOW+1), sample/match counter width
- PW (localparam), $clog2(WIDTH+1), per-sample popcount width (4 for WIDTH=8)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  pred/label pair valid
- in_ready  out  1  monitor can accept a pair this cycle
- pred  in  WIDTH  classifier output (outp of classifier stage)
- label  in  WIDTH  golden label
- flush  in  1  one-cycle pulse: report partial window
- clear  in  1  synchronous discard of all state, highest priority
- rep_valid  out  1  summary record valid
- rep_ready  in  1  consumer takes record
- rep_samples  out  CW  samples in record
- rep_match  out  CW  samples with pred == label
- rep_biterr  out  CW+PW  sum of popcount(pred ^ label)
- rep_worst  out  PW  max popcount(pred ^ label) in window

## Operation
- States: ACCUM, REPORT. Reset/clear → ACCUM, all counters 0, pipeline empty, flush_pend 0.
- Accept = in_valid && in_ready. in_ready = (state==ACCUM) && (issued != WINDOW) && !flush_pend && !clear.
- issued: count of accepted pairs in current window, +1 per accept.
- Stage S1 (register): on accept, d1 <= pred ^ label, v1 <= 1; else v1 <= 0.
- Stage S2 (accumulate, when v1): samples+1; match+1 if d1==0; biterr += popcount(d1); worst <= max(worst, popcount(d1)).
- ACCUM → REPORT when S2 updates with samples reaching WINDOW, or when flush_pend && pipeline empty (v1==0) && samples != 0.
- Entry into REPORT: rep_* loaded from the updated counters; rep_valid <= 1.
- REPORT: rep_* stable while rep_valid && !rep_ready. On handshake: counters, issued, flush_pend cleared; rep_valid <= 0; state → ACCUM.
- flush: pulse in ACCUM sets flush_pend. With samples==0, issued==0 and v1==0, flush is dropped (no empty report). flush in REPORT is ignored.
- clear: one-cycle synchronous reset of state, counters, S1, flush_pend; a pending record is discarded (rep_valid → 0). Any pair presented that cycle is not accepted.
- No counter saturates: widths are sized so WINDOW samples cannot overflow (biterr max WINDOW*WIDTH).

## Timing
- Reset values: in_ready 0 during reset, 1 from first cycle after deassertion; rep_valid 0; rep_samples, rep_match, rep_biterr, rep_worst all 0.
- Accept at cycle t → counters reflect that sample from t+2.
- WINDOW-th accept at t → rep_valid high at t+2; in_ready low from t+1.
- Minimum bubble: in_ready returns high in the cycle after the rep handshake.
- Throughput: one pair per cycle inside a window; overhead per window ≥ 2 cycles + consumer latency.
- flush at t with last accept at t-1 → rep_valid at t+2 (flush_pend set t+1, pipeline empty after t).
- Simultaneous flush and accept: the accept is taken (in_ready was already high); the sample is included in the partial report.
- Simultaneous clear with anything: clear wins.
- Async reset mid-window or mid-report: immediate return to reset values; no record emitted.

## Test plan
- WINDOW=4: pairs (0x00,0x00),(0xFF,0x00),(0x0F,0x0E),(0x3C,0x3C) back-to-back, rep_ready=1 → one record: samples=4, match=2, biterr=9, worst=8; rep_valid exactly 2 cycles after the 4th accept.
- Back-pressure: hold rep_ready=0 for 10 cycles → rep_* stable, in_ready=0 throughout, no input accepted; release → next window starts clean (counts from 0).
- Flush: 2 pairs (0xA5,0x5A),(0x01,0x01), then flush → samples=2, match=1, biterr=8, worst=8. Flush on idle, empty monitor → no record.
- Clear at REPORT with rep_valid=1 → rep_valid=0 next cycle, following window of 4 identical pairs reports match=4, biterr=0, worst=0.
- Async reset asserted 2 cycles into a window → all outputs 0 immediately; after release a full window reports only post-reset samples.
- Random traffic (random in_valid/rep_ready, WINDOW=256) vs scoreboard model: every record matches; no pair lost or double-counted.
